// File: rtl/result_writer_if.sv
// Result handshake between the arithmetic controller and the result writer.
//   res_valid  controller strobe: result present this cycle
//   res_ready  writer can take a record this cycle
//   op         0 = multiply, 1 = divide
//   resultado  product or quotient
//   resto      remainder (0 for multiply)
// master = controller side, slave = writer side.
interface result_writer_if;
  logic        res_valid;
  logic        res_ready;
  logic        op;
  logic [15:0] resultado;
  logic [15:0] resto;

  modport master (output res_valid, op, resultado, resto, input res_ready);
  modport slave  (input res_valid, op, resultado, resto, output res_ready);
endinterface

// File: rtl/result_writer.sv
// result_writer: buffers finished arithmetic results in a small FIFO and
// streams each one into an 8-bit x 512 result RAM as a little-endian byte
// record: resultado[7:0], resultado[15:8], resto[7:0], resto[15:8].
//
// Optional build macro RESULT_WRITER_TAG_EN: prefixes every record with a
// tag byte {4'hA, 3'b000, op} (5-byte records). Undefined: 4-byte records,
// op is ignored.
//
// Ports:
//   clk, rst_n   clock (rising edge), synchronous active-low reset
//   res          result handshake (slave side of result_writer_if)
//   mem_we       RAM write enable, one byte per cycle
//   mem_addr     RAM byte address
//   mem_data     RAM write data
//   busy         FIFO non-empty or a record in flight
//   mem_full     RAM has no room for another record (sticky until reset)
//   rec_count    records completely written
module result_writer #(
  parameter int DEPTH     = 4,
  parameter int BASE_ADDR = 0,
  parameter int ADDR_W    = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  result_writer_if.slave    res,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              busy,
  output logic              mem_full,
  output logic [7:0]        rec_count
);

`ifdef RESULT_WRITER_TAG_EN
  localparam int REC_BYTES = 5;
  localparam int DW        = 33;   // {op, resto, resultado}
`else
  localparam int REC_BYTES = 4;
  localparam int DW        = 32;   // {resto, resultado}
`endif
  localparam int SW      = 8 * REC_BYTES;
  localparam int MAX_REC = ((1 << ADDR_W) - BASE_ADDR) / REC_BYTES;
  localparam int PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW      = 10;
  localparam logic [2:0]        LAST_IDX  = 3'(REC_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

  typedef enum logic [1:0] {IDLE, LOAD, WRITE} state_t;

  state_t state, state_nxt;

  // ---------------------------------------------------------------- FIFO
  logic [DEPTH-1:0][DW-1:0] fifo_mem;
  logic [PW-1:0]            wr_ptr, rd_ptr;
  logic [PW:0]              fifo_cnt;
  logic                     fifo_full, fifo_empty;
  logic                     push, pop;
  logic [DW-1:0]            push_data, head;
  logic [SW-1:0]            staged;
  logic [CW-1:0]            alloc_count;

  assign fifo_full  = (fifo_cnt == (PW+1)'(DEPTH));
  assign fifo_empty = (fifo_cnt == '0);
  assign mem_full   = (alloc_count == CW'(MAX_REC));

  // Ready depends only on registered state, so there is no path from
  // res_valid back to res_ready. A full FIFO refuses even while popping.
  assign res.res_ready = !fifo_full && !mem_full;
  assign push          = res.res_valid && res.res_ready;
  assign head          = fifo_mem[rd_ptr];

`ifdef RESULT_WRITER_TAG_EN
  assign push_data = {res.op, res.resto, res.resultado};
  assign staged    = {head[31:0], 4'hA, 3'b000, head[32]};
`else
  logic unused_op;
  assign unused_op = res.op;
  assign push_data = {res.resto, res.resultado};
  assign staged    = head;
`endif

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + (PW+1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (PW+1)'(1);
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------- FSM
  // The head is popped into the shift register on the edge that enters
  // LOAD; the LOAD cycle then presents byte 0 so the first byte appears two
  // edges after the accept. Each record costs one LOAD bubble.
  logic [2:0]    byte_idx;   // index of the byte currently on mem_data
  logic [2:0]    emit_idx;
  logic          last_byte;
  logic          emit;       // put the next byte on the bus at this edge
  logic          step;       // advance mem_addr at this edge
  logic [SW-1:0] shreg;

  assign last_byte = (byte_idx == LAST_IDX);
  assign busy      = (state != IDLE) || !fifo_empty;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    emit      = 1'b0;
    step      = 1'b0;
    emit_idx  = byte_idx + 3'd1;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        emit      = 1'b1;
        emit_idx  = 3'd0;
        state_nxt = WRITE;
      end
      WRITE: begin
        // Step on every WRITE cycle: within the record, and once more on
        // exit so mem_addr rests on the next free byte.
        step = 1'b1;
        if (!last_byte) begin
          emit = 1'b1;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = LOAD;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg       <= '0;
      byte_idx    <= '0;
      mem_we      <= 1'b0;
      mem_addr    <= ADDR_W'(BASE_ADDR);
      mem_data    <= '0;
      rec_count   <= '0;
      alloc_count <= '0;
    end else begin
      mem_we <= emit;
      if (push) alloc_count <= alloc_count + CW'(1);
      if (pop) begin
        shreg    <= staged;
        byte_idx <= '0;
      end
      if (emit) begin
        mem_data <= shreg[7:0];
        shreg    <= shreg >> 8;
        byte_idx <= emit_idx;
        if (emit_idx == LAST_IDX) rec_count <= rec_count + 8'd1;
      end
      // Saturate at the top of RAM rather than wrapping back to 0.
      if (step && mem_addr != ADDR_LAST) mem_addr <= mem_addr + ADDR_W'(1);
    end
  end

endmodule

// File: tb/tb_result_writer.sv
module tb_result_writer;
`ifdef RESULT_WRITER_TAG_EN
  localparam int RB = 5;
`else
  localparam int RB = 4;
`endif
  localparam int MAXR1 = 12 / RB;   // records that fit in 500..511

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  result_writer_if rif0();
  result_writer_if rif1();

  logic       we0, we1, busy0, busy1, full0, full1;
  logic [8:0] addr0, addr1;
  logic [7:0] data0, data1, rc0, rc1;

  result_writer #(.DEPTH(4), .BASE_ADDR(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .res(rif0),
    .mem_we(we0), .mem_addr(addr0), .mem_data(data0),
    .busy(busy0), .mem_full(full0), .rec_count(rc0));

  result_writer #(.DEPTH(4), .BASE_ADDR(500)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .res(rif1),
    .mem_we(we1), .mem_addr(addr1), .mem_data(data1),
    .busy(busy1), .mem_full(full1), .rec_count(rc1));

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t log0[$];
  wr_t log1[$];
  int  max_addr1 = 0;

  always @(negedge clk) begin
    if (we0) log0.push_back('{cyc, int'(addr0), int'(data0)});
    if (we1) log1.push_back('{cyc, int'(addr1), int'(data1)});
    if (int'(addr1) > max_addr1) max_addr1 = int'(addr1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic o,
                       input logic [15:0] r, input logic [15:0] q);
    if (p == 0) begin
      rif0.res_valid = v; rif0.op = o; rif0.resultado = r; rif0.resto = q;
    end else begin
      rif1.res_valid = v; rif1.op = o; rif1.resultado = r; rif1.resto = q;
    end
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? rif0.res_ready : rif1.res_ready;
  endfunction

  function automatic logic bsy(input int p);
    return (p == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [15:0] rv(input int i);
    return {8'(16 + i), 8'(160 + i)};
  endfunction

  function automatic logic [15:0] qv(input int i);
    return {8'h00, 8'(3 * i)};
  endfunction

  // Byte i of the record as it must appear in RAM.
  function automatic int exp_byte(input logic o, input logic [15:0] r,
                                  input logic [15:0] q, input int i);
    logic [39:0] b;
`ifdef RESULT_WRITER_TAG_EN
    b = {q, r, 4'hA, 3'b000, o};
`else
    b = {8'h00, q, r};
`endif
    return int'(b[i*8 +: 8]);
  endfunction

  // Present one result, wait for ready, return the edge it was accepted on.
  task automatic send(input int p, input logic o, input logic [15:0] r,
                      input logic [15:0] q, output int acc);
    int n;
    @(negedge clk);
    drive(p, 1'b1, o, r, q);
    n = 0;
    while (!rdy(p) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk("send_timeout", 0, 1);
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
    drive(p, 1'b0, 1'b0, 16'h0, 16'h0);
  endtask

  task automatic wait_cyc(input int c);
    do @(negedge clk); while (cyc < c);
  endtask

  task automatic wait_idle(input int p);
    int n;
    n = 0;
    @(negedge clk);
    while (bsy(p) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) chk("idle_timeout", 0, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    log0.delete();
    log1.delete();
    max_addr1 = 0;
  endtask

  task automatic check_rec(input int p, input int k, input int base, input logic o,
                           input logic [15:0] r, input logic [15:0] q);
    for (int i = 0; i < RB; i++) begin
      int  j;
      wr_t w;
      j = k * RB + i;
      if (j < ((p == 0) ? log0.size() : log1.size())) begin
        w = (p == 0) ? log0[j] : log1[j];
        chk($sformatf("p%0d_rec%0d_b%0d_addr", p, k, i), w.addr, base + j);
        chk($sformatf("p%0d_rec%0d_b%0d_data", p, k, i), w.data, exp_byte(o, r, q, i));
      end else begin
        chk($sformatf("p%0d_rec%0d_b%0d_missing", p, k, i), 0, 1);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, m, acc_stall, stalls, accepted;
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);

    // ---- reset state
    repeat (3) @(negedge clk);
    chk("rst_we",    we0,   0);
    chk("rst_addr0", addr0, 0);
    chk("rst_data",  data0, 0);
    chk("rst_rc",    rc0,   0);
    chk("rst_full",  full0, 0);
    chk("rst_busy",  busy0, 0);
    chk("rst_ready", rif0.res_ready, 1);
    chk("rst_addr1", addr1, 500);
    rst_n = 1'b1;
    log0.delete();
    log1.delete();

    // ---- single multiply: latency and layout
    send(0, 1'b0, 16'h00C8, 16'h0000, n);
    wait_cyc(n + 1);
    chk("p1_we_after_pop", we0, 0);
    wait_cyc(n + RB);
    chk("p1_rc_before_last", rc0, 0);
    wait_cyc(n + RB + 1);
    chk("p1_we_last", we0, 1);
    chk("p1_rc_after_last", rc0, 1);
    wait_cyc(n + RB + 2);
    chk("p1_we_done", we0, 0);
    chk("p1_busy_done", busy0, 0);
    chk("p1_addr_next", addr0, RB);
    chk("p1_nbytes", log0.size(), RB);
    if (log0.size() >= RB) begin
      chk("p1_first_cyc", log0[0].cyc, n + 2);
      chk("p1_last_cyc", log0[RB-1].cyc, n + RB + 1);
    end
    check_rec(0, 0, 0, 1'b0, 16'h00C8, 16'h0000);

    // ---- division posted while a multiply is mid-write
    do_reset();
    send(0, 1'b0, 16'h00C8, 16'h0000, n);
    wait_cyc(n + 2);
    send(0, 1'b1, 16'h0007, 16'h0003, m);
    chk("p2_mid_write", (m > n + 1 && m < n + RB + 1), 1);
    wait_idle(0);
    chk("p2_nbytes", log0.size(), 2 * RB);
    check_rec(0, 0, 0, 1'b0, 16'h00C8, 16'h0000);
    check_rec(0, 1, 0, 1'b1, 16'h0007, 16'h0003);
    if (log0.size() > RB) chk("p2_one_bubble", log0[RB].cyc - log0[RB-1].cyc, 2);
    chk("p2_rc", rc0, 2);
    chk("p2_addr_next", addr0, 2 * RB);

    // ---- six results with res_valid held high
    do_reset();
    acc_stall = -1;
    stalls    = 0;
    accepted  = 0;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      int t;
      t = 0;
      drive(0, 1'b1, 1'(i), rv(i), qv(i));
      while (!rif0.res_ready && t < 50) begin
        if (acc_stall < 0) acc_stall = accepted;
        stalls++;
        @(posedge clk);
        #1;
        t++;
      end
      @(posedge clk);
      #1;
      accepted++;
    end
    drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_idle(0);
    chk("p3_accepts_before_stall", acc_stall, 5);
    chk("p3_stall_cycles", stalls, RB - 2);
    chk("p3_nbytes", log0.size(), 6 * RB);
    for (int i = 0; i < 6; i++) check_rec(0, i, 0, 1'(i), rv(i), qv(i));
    chk("p3_rc", rc0, 6);

    // ---- BASE_ADDR=500 capacity limit
    do_reset();
    for (int k = 0; k < MAXR1; k++) begin
      chk($sformatf("p4_full_before_%0d", k), full1, 0);
      send(1, 1'b0, rv(k), qv(k), n);
    end
    chk("p4_full_set", full1, 1);
    chk("p4_ready_low", rif1.res_ready, 0);
    @(negedge clk);
    drive(1, 1'b1, 1'b0, 16'hDEAD, 16'hBEEF);
    repeat (30) @(negedge clk);
    drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
    wait_idle(1);
    chk("p4_rc", rc1, MAXR1);
    chk("p4_nbytes", log1.size(), MAXR1 * RB);
    for (int k = 0; k < MAXR1; k++) check_rec(1, k, 500, 1'b0, rv(k), qv(k));
    chk("p4_addr_max", max_addr1 <= 511, 1);
    chk("p4_addr_final", addr1, (500 + MAXR1 * RB > 511) ? 511 : 500 + MAXR1 * RB);
    chk("p4_full_sticky", full1, 1);

    // ---- reset during byte 2
    do_reset();
    send(0, 1'b0, 16'h5566, 16'h7788, n);
    wait_cyc(n + 4);
    chk("p5_byte2_addr", addr0, 2);
    rst_n = 1'b0;
    wait_cyc(n + 5);
    chk("p5_we", we0, 0);
    chk("p5_addr", addr0, 0);
    chk("p5_rc", rc0, 0);
    chk("p5_busy", busy0, 0);
    rst_n = 1'b1;
    log0.delete();
    send(0, 1'b0, 16'hABCD, 16'h0042, n);
    wait_idle(0);
    chk("p5_nbytes", log0.size(), RB);
    check_rec(0, 0, 0, 1'b0, 16'hABCD, 16'h0042);
    chk("p5_rc_after", rc0, 1);

`ifdef RESULT_WRITER_TAG_EN
    // ---- tagged record, literal byte image
    begin
      int exp_b[5];
      exp_b = '{32'hA1, 32'h34, 32'h12, 32'h01, 32'h00};
      do_reset();
      send(0, 1'b1, 16'h1234, 16'h0001, n);
      wait_idle(0);
      chk("p6_nbytes", log0.size(), 5);
      for (int i = 0; i < 5; i++) begin
        if (i < log0.size()) begin
          chk($sformatf("p6_b%0d_addr", i), log0[i].addr, i);
          chk($sformatf("p6_b%0d_data", i), log0[i].data, exp_b[i]);
        end
      end
      chk("p6_rc", rc0, 1);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
